// File: rtl/writeback_stage.sv
// MEM/WB register with load extraction, write-back select, retire counter and sticky misalign flag.
// One-cycle latency; flush beats stall beats capture, and a stall holds every registered value.
module writeback_stage #(
  parameter int          COUNT_WIDTH = 32,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   memValid,
  input  logic                   memStall,
  input  logic                   memFlush,
  input  logic                   memRegWrite,
  input  logic                   memMemToReg,
  input  logic                   memLink,
  input  logic [2:0]             memLoadType,
  input  logic [1:0]             memAddrLow,
  input  logic [31:0]            memAluResult,
  input  logic [31:0]            memReadData,
  input  logic [31:0]            memPc,
  input  logic [4:0]             memWriteRegNumber,
  output logic                   regWriteSignal,
  output logic [4:0]             writeRegNumber,
  output logic [31:0]            writeData,
  output logic                   wbValid,
  output logic [COUNT_WIDTH-1:0] retiredCount,
  output logic                   misalignErr
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic                   valid_q;
  logic                   reg_write_q;
  logic                   mem_to_reg_q;
  logic                   link_q;
  logic [2:0]             load_type_q;
  logic [1:0]             addr_low_q;
  logic [31:0]            alu_q;
  logic [31:0]            rdata_q;
  logic [31:0]            pc_q;
  logic [4:0]             rd_q;
  logic                   misaligned_q;
  logic                   err_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   misaligned_in;

  // Halfword loads only need bit 0 clear; everything not a byte/halfword load is a word load.
  always_comb begin
    misaligned_in = 1'b0;
    if (memMemToReg && !memLink) begin
      case (memLoadType)
        LT_LB, LT_LBU: misaligned_in = 1'b0;
        LT_LH, LT_LHU: misaligned_in = memAddrLow[0];
        default:       misaligned_in = (memAddrLow != 2'b00);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      load_type_q  <= 3'b000;
      addr_low_q   <= 2'b00;
      alu_q        <= 32'h0;
      rdata_q      <= 32'h0;
      pc_q         <= 32'h0;
      rd_q         <= 5'd0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else if (memFlush || (!memStall && !memValid)) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      load_type_q  <= 3'b000;
      addr_low_q   <= 2'b00;
      alu_q        <= 32'h0;
      rdata_q      <= 32'h0;
      pc_q         <= 32'h0;
      rd_q         <= 5'd0;
      misaligned_q <= 1'b0;
    end else if (!memStall) begin
      valid_q      <= 1'b1;
      reg_write_q  <= memRegWrite;
      mem_to_reg_q <= memMemToReg;
      link_q       <= memLink;
      load_type_q  <= memLoadType;
      addr_low_q   <= memAddrLow;
      alu_q        <= memAluResult;
      rdata_q      <= memReadData;
      pc_q         <= memPc;
      rd_q         <= memWriteRegNumber;
      misaligned_q <= misaligned_in;
      if (misaligned_in) err_q <= 1'b1;
      else               count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  always_comb begin
    lane_byte = rdata_q[8*addr_low_q +: 8];
    lane_half = addr_low_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (load_type_q)
      LT_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      LT_LBU:  load_data = {24'h0, lane_byte};
      LT_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      LT_LHU:  load_data = {16'h0, lane_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    if (link_q)            writeData = pc_q + LINK_OFFSET;
    else if (mem_to_reg_q) writeData = load_data;
    else                   writeData = alu_q;
  end

  assign regWriteSignal = valid_q & reg_write_q & (rd_q != 5'd0) & ~misaligned_q;
  assign writeRegNumber = rd_q;
  assign wbValid        = valid_q;
  assign retiredCount   = count_q;
  assign misalignErr    = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Vector-table bench for writeback_stage with a scoreboard queue of expected WB outputs.
module tb_writeback_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          memValid, memStall, memFlush, memRegWrite, memMemToReg, memLink;
  logic [2:0]    memLoadType;
  logic [1:0]    memAddrLow;
  logic [31:0]   memAluResult, memReadData, memPc;
  logic [4:0]    memWriteRegNumber;
  logic          regWriteSignal;
  logic [4:0]    writeRegNumber;
  logic [31:0]   writeData;
  logic          wbValid;
  logic [CW-1:0] retiredCount;
  logic          misalignErr;

  writeback_stage #(.COUNT_WIDTH(CW), .LINK_OFFSET(32'd8)) dut (
    .clk(clk), .rst_n(rst_n),
    .memValid(memValid), .memStall(memStall), .memFlush(memFlush),
    .memRegWrite(memRegWrite), .memMemToReg(memMemToReg), .memLink(memLink),
    .memLoadType(memLoadType), .memAddrLow(memAddrLow),
    .memAluResult(memAluResult), .memReadData(memReadData), .memPc(memPc),
    .memWriteRegNumber(memWriteRegNumber),
    .regWriteSignal(regWriteSignal), .writeRegNumber(writeRegNumber),
    .writeData(writeData), .wbValid(wbValid), .retiredCount(retiredCount),
    .misalignErr(misalignErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, flush, rw, m2r, link;
    logic [2:0]  lt;
    logic [1:0]  al;
    logic [31:0] alu, rdata, pc;
    logic [4:0]  rd;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_wbv, inc, e_mis;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        wbv;
    logic [CW-1:0] cnt;
    logic        mis;
  } exp_t;

  vec_t          vecs[$];
  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  function automatic vec_t mk(input logic valid, stall, flush, rw, m2r, link,
                              input logic [2:0] lt, input logic [1:0] al,
                              input logic [31:0] alu, rdata, pc, input logic [4:0] rd,
                              input logic e_we, input logic [4:0] e_rd,
                              input logic [31:0] e_wd, input logic e_wbv, inc, e_mis);
    vec_t v;
    v.valid = valid; v.stall = stall; v.flush = flush; v.rw = rw; v.m2r = m2r;
    v.link = link; v.lt = lt; v.al = al; v.alu = alu; v.rdata = rdata; v.pc = pc;
    v.rd = rd; v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd; v.e_wbv = e_wbv;
    v.inc = inc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " regWriteSignal"}, 32'(regWriteSignal), 32'h0);
    check({tag, " writeRegNumber"}, 32'(writeRegNumber), 32'h0);
    check({tag, " writeData"}, writeData, 32'h0);
    check({tag, " wbValid"}, 32'(wbValid), 32'h0);
    check({tag, " retiredCount"}, 32'(retiredCount), 32'h0);
    check({tag, " misalignErr"}, 32'(misalignErr), 32'h0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    memValid = v.valid; memStall = v.stall; memFlush = v.flush; memRegWrite = v.rw;
    memMemToReg = v.m2r; memLink = v.link; memLoadType = v.lt; memAddrLow = v.al;
    memAluResult = v.alu; memReadData = v.rdata; memPc = v.pc; memWriteRegNumber = v.rd;
    if (v.inc) exp_cnt = exp_cnt + 1'b1;
    e.we = v.e_we; e.rd = v.e_rd; e.wd = v.e_wd; e.wbv = v.e_wbv; e.cnt = exp_cnt; e.mis = v.e_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, " regWriteSignal"}, 32'(regWriteSignal), 32'(got.we));
    check({tag, " writeRegNumber"}, 32'(writeRegNumber), 32'(got.rd));
    check({tag, " writeData"}, writeData, got.wd);
    check({tag, " wbValid"}, 32'(wbValid), 32'(got.wbv));
    check({tag, " retiredCount"}, 32'(retiredCount), 32'(got.cnt));
    check({tag, " misalignErr"}, 32'(misalignErr), 32'(got.mis));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    localparam logic [31:0] RD = 32'h80FF_7F01;
    rst_n = 1'b0;
    memValid = 0; memStall = 0; memFlush = 0; memRegWrite = 0; memMemToReg = 0;
    memLink = 0; memLoadType = 0; memAddrLow = 0; memAluResult = 0; memReadData = 0;
    memPc = 0; memWriteRegNumber = 0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    //         vl st fl rw m2r lk lt     al     alu          rdata pc            rd   we rd  wd            wbv inc mis
    vecs.push_back(mk(1,0,0,1,0,0,3'd0,2'd0,32'h0000_1234,32'h0,32'h0,        5'd5, 1,5'd5, 32'h0000_1234,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,3'd0,2'd0,32'h0,        32'h0,32'h0,        5'd0, 0,5'd0, 32'h0,        0,0,0));
    vecs.push_back(mk(1,0,0,1,1,0,3'd1,2'd3,32'h0,        RD,   32'h0,        5'd2, 1,5'd2, 32'hFFFF_FF80,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,0,3'd2,2'd3,32'h0,        RD,   32'h0,        5'd2, 1,5'd2, 32'h0000_0080,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,0,3'd3,2'd2,32'h0,        RD,   32'h0,        5'd2, 1,5'd2, 32'hFFFF_80FF,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,0,3'd4,2'd0,32'h0,        RD,   32'h0,        5'd2, 1,5'd2, 32'h0000_7F01,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,0,3'd0,2'd0,32'h0,        RD,   32'h0,        5'd2, 1,5'd2, 32'h80FF_7F01,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,0,3'd1,2'd1,32'h0,        RD,   32'h0,        5'd3, 1,5'd3, 32'h0000_007F,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,0,3'd4,2'd2,32'h0,        RD,   32'h0,        5'd3, 1,5'd3, 32'h0000_80FF,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,1,3'd0,2'd2,32'h0000_0777,RD,   32'h0040_0010,5'd31,1,5'd31,32'h0040_0018,1,1,0));
    vecs.push_back(mk(1,0,0,1,1,1,3'd0,2'd2,32'h0000_0777,RD,   32'h0040_0010,5'd0, 0,5'd0, 32'h0040_0018,1,1,0));
    vecs.push_back(mk(1,0,1,1,0,0,3'd0,2'd0,32'h0000_5555,32'h0,32'h0,        5'd5, 0,5'd0, 32'h0,        0,0,0));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Stall holds A while B waits on the inputs, then B is captured; flush wins over stall.
    apply(mk(1,0,0,1,0,0,3'd0,2'd0,32'h0000_AAAA,32'h0,32'h0,5'd3, 1,5'd3,32'h0000_AAAA,1,1,0), "stallA");
    apply(mk(1,1,0,1,0,0,3'd0,2'd0,32'h0000_BBBB,32'h0,32'h0,5'd4, 1,5'd3,32'h0000_AAAA,1,0,0), "stall1");
    apply(mk(1,1,0,1,0,0,3'd0,2'd0,32'h0000_BBBB,32'h0,32'h0,5'd4, 1,5'd3,32'h0000_AAAA,1,0,0), "stall2");
    apply(mk(1,0,0,1,0,0,3'd0,2'd0,32'h0000_BBBB,32'h0,32'h0,5'd4, 1,5'd4,32'h0000_BBBB,1,1,0), "captB");
    apply(mk(1,1,1,1,0,0,3'd0,2'd0,32'h0000_CCCC,32'h0,32'h0,5'd6, 0,5'd0,32'h0,        0,0,0), "flushstall");

    apply(mk(1,0,0,1,1,0,3'd0,2'd2,32'h0,RD,32'h0,5'd7, 0,5'd7,RD,           1,0,1), "misLW");
    apply(mk(1,0,0,1,1,0,3'd3,2'd3,32'h0,RD,32'h0,5'd8, 0,5'd8,32'hFFFF_80FF,1,0,1), "misLH");
    for (int i = 0; i < 10; i++)
      apply(mk(1,0,0,1,0,0,3'd0,2'd0,32'(i + 100),32'h0,32'h0,5'd9, 1,5'd9,32'(i + 100),1,1,1),
            $sformatf("sticky%0d", i));

    // Reset between edges with an instruction in flight.
    memValid = 1; memRegWrite = 1; memAluResult = 32'h0000_DEAD; memWriteRegNumber = 5'd10;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;

    for (int i = 0; i < 17; i++)
      apply(mk(1,0,0,1,0,0,3'd0,2'd0,32'(i + 1),32'h0,32'h0,5'd12, 1,5'd12,32'(i + 1),1,1,0),
            $sformatf("wrap%0d", i));
    check("wrap_final", 32'(retiredCount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
